// File: rtl/mem_map_pkg.sv
// Memory map for data_memory: MMIO window base, register offsets and the
// STATUS register layout shared by the top and its debug FIFO logic.
package mem_map_pkg;

  localparam logic [31:0] MMIO_BASE_DEFAULT = 32'hFFFF_FF00;

  // Register offsets inside the 256-byte MMIO window
  localparam logic [7:0] MMIO_TXDATA = 8'h00;
  localparam logic [7:0] MMIO_STATUS = 8'h04;

  // STATUS bit positions
  localparam int ST_EMPTY = 0;
  localparam int ST_FULL  = 1;
  localparam int ST_OVF   = 2;

  // STATUS register image; last member lands in bit 0
  typedef struct packed {
    logic [28:0] rsvd;
    logic        overflow;
    logic        full;
    logic        empty;
  } status_t;

  // Build a STATUS word from the three live flags
  function automatic status_t make_status(input logic overflow,
                                          input logic full,
                                          input logic empty);
    status_t s;
    s          = '0;
    s.overflow = overflow;
    s.full     = full;
    s.empty    = empty;
    return s;
  endfunction

endpackage

// File: rtl/sync_fifo.sv
// Synchronous first-word-fall-through FIFO. Pointers carry one extra wrap
// bit so full and empty are told apart without a separate counter.
// A push while full is accepted only if a pop frees a slot in the same cycle;
// otherwise it is dropped and flagged on 'drop' for that cycle.
//
// Handshake: 'pop' is a request from the consumer; it only takes effect when
// the FIFO is non-empty. 'head' always shows the oldest stored word.
module sync_fifo #(
  parameter int WIDTH = 32,
  parameter int DEPTH = 4
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             push,
  input  logic [WIDTH-1:0] push_data,
  input  logic             pop,
  output logic             full,
  output logic             empty,
  output logic [WIDTH-1:0] head,
  output logic             drop
);

  localparam int IW = $clog2(DEPTH);

  logic [IW:0]      wr_ptr;
  logic [IW:0]      rd_ptr;
  logic [WIDTH-1:0] mem [DEPTH];
  logic             pop_ok;
  logic             push_ok;

  assign empty   = (wr_ptr == rd_ptr);
  assign full    = (wr_ptr[IW] != rd_ptr[IW]) &&
                   (wr_ptr[IW-1:0] == rd_ptr[IW-1:0]);
  assign pop_ok  = pop && !empty;
  // A same-cycle pop frees the slot the write pointer is aimed at
  assign push_ok = push && (!full || pop_ok);
  assign drop    = push && !push_ok;
  assign head    = mem[rd_ptr[IW-1:0]];

  // Pointer update; reset empties the FIFO
  always_ff @(posedge clk) begin
    if (reset) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
    end else begin
      if (push_ok) wr_ptr <= wr_ptr + (IW+1)'(1);
      if (pop_ok)  rd_ptr <= rd_ptr + (IW+1)'(1);
    end
  end

  // Storage write; contents need no reset since pointers gate visibility
  always_ff @(posedge clk) begin
    if (push_ok) mem[wr_ptr[IW-1:0]] <= push_data;
  end

endmodule

// File: rtl/data_memory.sv
// Word-addressed data memory for the single-cycle core with an MMIO debug
// output port. Combinational read, write at the rising edge.
// Optional feature macro: DMEM_DEBUG_FIFO_EN (debug FIFO + STATUS register).
// Without it, MMIO accesses still decode but read 0 and ignore writes.
//
// Debug handshake: a word transfers on every rising edge where
// dbg_valid && dbg_ready; dbg_data is the head word while dbg_valid is high.
module data_memory
  import mem_map_pkg::*;
#(
  parameter int          DEPTH_WORDS = 64,
  parameter int          FIFO_DEPTH  = 4,
  parameter logic [31:0] MMIO_BASE   = MMIO_BASE_DEFAULT
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        mem_write,
  input  logic [31:0] addr,
  input  logic [31:0] write_data,
  output logic [31:0] read_data,
  output logic        dbg_valid,
  output logic [31:0] dbg_data,
  input  logic        dbg_ready,
  output logic        dbg_overflow
);

  localparam int AW = $clog2(DEPTH_WORDS);

  logic [31:0]   ram [DEPTH_WORDS];
  logic          mmio_hit;
  logic [AW-1:0] ram_idx;
  logic [31:0]   mmio_rdata;
  logic          unused_sigs;

  assign mmio_hit = (addr[31:8] == MMIO_BASE[31:8]);
  // Byte offset and out-of-range upper bits are dropped: addresses alias
  assign ram_idx  = addr[AW+1:2];

  // RAM store; unaffected by reset
  always_ff @(posedge clk) begin
    if (mem_write && !mmio_hit) ram[ram_idx] <= write_data;
  end

  // Load path: zero-latency mux between RAM and MMIO read data
  always_comb begin
    read_data = ram[ram_idx];
    if (mmio_hit) read_data = mmio_rdata;
  end

`ifdef DMEM_DEBUG_FIFO_EN

  logic    push;
  logic    drop;
  logic    ovf_clr;
  logic    fifo_full;
  logic    fifo_empty;
  logic    ovf_q;
  status_t status;

  assign push    = mem_write && mmio_hit && (addr[7:0] == MMIO_TXDATA);
  assign ovf_clr = mem_write && mmio_hit && (addr[7:0] == MMIO_STATUS) &&
                   write_data[ST_OVF];

  sync_fifo #(
    .WIDTH (32),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk       (clk),
    .reset     (reset),
    .push      (push),
    .push_data (write_data),
    .pop       (dbg_valid && dbg_ready),
    .full      (fifo_full),
    .empty     (fifo_empty),
    .head      (dbg_data),
    .drop      (drop)
  );

  assign dbg_valid    = !fifo_empty;
  assign dbg_overflow = ovf_q;
  assign status       = make_status(ovf_q, fifo_full, fifo_empty);

  // Sticky overflow flag; a same-cycle drop beats a software clear
  always_ff @(posedge clk) begin
    if (reset)        ovf_q <= 1'b0;
    else if (drop)    ovf_q <= 1'b1;
    else if (ovf_clr) ovf_q <= 1'b0;
  end

  // MMIO read decode: only STATUS returns data
  always_comb begin
    mmio_rdata = '0;
    if (addr[7:0] == MMIO_STATUS) mmio_rdata = status;
  end

`else

  assign dbg_valid    = 1'b0;
  assign dbg_data     = '0;
  assign dbg_overflow = 1'b0;
  assign mmio_rdata   = '0;

`endif

  // Collects inputs that some configurations leave unread
  assign unused_sigs = ^{addr, write_data, dbg_ready, reset, MMIO_BASE[7:0]};

endmodule

// File: tb/tb_data_memory.sv
// Self-checking bench for data_memory. A queue/array reference model is
// updated once per clock from the same rules the memory must obey, and every
// cycle the DUT's combinational and registered outputs are compared against it.
// Works with or without DMEM_DEBUG_FIFO_EN defined.
module tb_data_memory;

`ifdef DMEM_DEBUG_FIFO_EN
  localparam bit FIFO_EN = 1'b1;
`else
  localparam bit FIFO_EN = 1'b0;
`endif
  localparam int DEPTH_WORDS = 64;
  localparam int FIFO_DEPTH  = 4;
  localparam logic [31:0] MMIO = 32'hFFFF_FF00;

  // ---------------- clock / reset ----------------
  logic        clk = 1'b0;
  logic        reset;
  logic        mem_write;
  logic [31:0] addr;
  logic [31:0] write_data;
  logic [31:0] read_data;
  logic        dbg_valid;
  logic [31:0] dbg_data;
  logic        dbg_ready;
  logic        dbg_overflow;

  always #5 clk = ~clk;

  data_memory #(
    .DEPTH_WORDS (DEPTH_WORDS),
    .FIFO_DEPTH  (FIFO_DEPTH),
    .MMIO_BASE   (MMIO)
  ) dut (
    .clk          (clk),
    .reset        (reset),
    .mem_write    (mem_write),
    .addr         (addr),
    .write_data   (write_data),
    .read_data    (read_data),
    .dbg_valid    (dbg_valid),
    .dbg_data     (dbg_data),
    .dbg_ready    (dbg_ready),
    .dbg_overflow (dbg_overflow)
  );

  // ---------------- reference model ----------------
  logic [31:0] ref_ram   [DEPTH_WORDS];
  bit          ram_known [DEPTH_WORDS];
  logic [31:0] exp_q[$];
  bit          ref_ovf;
  bit          model_live;

  int n_tests = 0;
  int n_fail  = 0;

  task automatic check(input string tag, input logic [31:0] got,
                       input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s got=%h expected=%h at %0t", tag, got, exp, $time);
    end
  endtask

  function automatic bit is_mmio(input logic [31:0] a);
    return (a >> 8) == (MMIO >> 8);
  endfunction

  function automatic int word_of(input logic [31:0] a);
    return int'((a / 4) % DEPTH_WORDS);
  endfunction

  function automatic logic [31:0] model_mmio_read(input logic [31:0] a);
    int off;
    off = int'(a % 256);
    if (FIFO_EN && off == 4)
      return (ref_ovf ? 32'd4 : 32'd0) +
             ((exp_q.size() == FIFO_DEPTH) ? 32'd2 : 32'd0) +
             ((exp_q.size() == 0) ? 32'd1 : 32'd0);
    return 32'd0;
  endfunction

  // Apply one clock edge to the model using the pre-edge inputs
  task automatic model_edge(input bit rst, input bit we, input logic [31:0] a,
                            input logic [31:0] wd, input bit rdy);
    bit popped;
    bit set_ovf;
    bit clr_ovf;
    int off;
    if (rst) begin
      exp_q.delete();
      ref_ovf    = 1'b0;
      model_live = 1'b1;
    end else if (model_live) begin
      popped  = 1'b0;
      set_ovf = 1'b0;
      clr_ovf = 1'b0;
      off     = int'(a % 256);
      if (FIFO_EN && rdy && exp_q.size() > 0) begin
        void'(exp_q.pop_front());
        popped = 1'b1;
      end
      if (FIFO_EN && we && is_mmio(a) && off == 0) begin
        if (exp_q.size() < FIFO_DEPTH) exp_q.push_back(wd);
        else set_ovf = 1'b1;
      end
      if (FIFO_EN && we && is_mmio(a) && off == 4 && wd[2]) clr_ovf = 1'b1;
      if (set_ovf)      ref_ovf = 1'b1;
      else if (clr_ovf) ref_ovf = 1'b0;
      if (popped && exp_q.size() > FIFO_DEPTH) ref_ovf = 1'b1;
    end
    if (we && !is_mmio(a)) begin
      ref_ram[word_of(a)]   = wd;
      ram_known[word_of(a)] = 1'b1;
    end
  endtask

  // ---------------- driver ----------------
  // Called at a falling edge: drive, check comb/registered outputs, clock once
  task automatic do_cycle(input string tag, input bit rst, input bit we,
                          input logic [31:0] a, input logic [31:0] wd,
                          input bit rdy);
    reset      = rst;
    mem_write  = we;
    addr       = a;
    write_data = wd;
    dbg_ready  = rdy;
    #1;
    if (is_mmio(a)) begin
      if (model_live) check({tag, "/mmio_rd"}, read_data, model_mmio_read(a));
    end else if (ram_known[word_of(a)]) begin
      check({tag, "/ram_rd"}, read_data, ref_ram[word_of(a)]);
    end
    if (model_live) begin
      check({tag, "/valid"}, 32'(dbg_valid), 32'(exp_q.size() > 0));
      check({tag, "/ovf"}, 32'(dbg_overflow), 32'(ref_ovf));
      if (!FIFO_EN) check({tag, "/data_off"}, dbg_data, 32'd0);
      else if (exp_q.size() > 0) check({tag, "/data"}, dbg_data, exp_q[0]);
    end
    model_edge(rst, we, a, wd, rdy);
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic idle(input string tag, input bit rdy, input int n);
    for (int i = 0; i < n; i++) do_cycle(tag, 1'b0, 1'b0, 32'h0, 32'h0, rdy);
  endtask

  // ---------------- stimulus ----------------
  initial begin
    logic [31:0] ra;
    int          pick;
    for (int i = 0; i < DEPTH_WORDS; i++) ram_known[i] = 1'b0;
    ref_ovf    = 1'b0;
    model_live = 1'b0;
    reset = 1'b1; mem_write = 1'b0; addr = '0; write_data = '0; dbg_ready = 1'b0;
    @(negedge clk);

    do_cycle("reset", 1'b1, 1'b0, 32'h0, 32'h0, 1'b0);
    do_cycle("reset", 1'b1, 1'b0, 32'h0, 32'h0, 1'b0);
    do_cycle("post_reset", 1'b0, 1'b0, MMIO + 4, 32'h0, 1'b0);
    if (FIFO_EN) check("status_reset", read_data, 32'h1);

    // Store then load, including read-during-write of the old value
    do_cycle("st_ld", 1'b0, 1'b1, 32'h10, 32'h1111_1111, 1'b0);
    do_cycle("st_ld_rdw", 1'b0, 1'b1, 32'h10, 32'hDEAD_BEEF, 1'b0);
    do_cycle("st_ld_rd", 1'b0, 1'b0, 32'h10, 32'h0, 1'b0);
    check("store_load", read_data, 32'hDEAD_BEEF);

    // Aliasing: byte offset ignored, wrap modulo 256 bytes
    do_cycle("alias_wr", 1'b0, 1'b1, 32'h13, 32'h1234, 1'b0);
    do_cycle("alias_10", 1'b0, 1'b0, 32'h10, 32'h0, 1'b0);
    check("alias_0x10", read_data, 32'h1234);
    do_cycle("alias_110", 1'b0, 1'b0, 32'h110, 32'h0, 1'b0);
    check("alias_0x110", read_data, 32'h1234);

    // FIFO order
    for (int i = 1; i <= 3; i++) do_cycle("fifo_push", 1'b0, 1'b1, MMIO, 32'(i), 1'b0);
    do_cycle("fifo_status", 1'b0, 1'b0, MMIO + 4, 32'h0, 1'b0);
    if (FIFO_EN) check("status_3q", read_data, 32'h0);
    idle("fifo_drain", 1'b1, 4);
    do_cycle("fifo_status2", 1'b0, 1'b0, MMIO + 4, 32'h0, 1'b1);
    if (FIFO_EN) check("status_drained", read_data, 32'h1);

    // Overflow: 5 pushes into 4 entries, drain, then clear
    for (int i = 0; i < 5; i++) do_cycle("ovf_push", 1'b0, 1'b1, MMIO, 32'h100 + 32'(i), 1'b0);
    do_cycle("ovf_status", 1'b0, 1'b0, MMIO + 4, 32'h0, 1'b0);
    if (FIFO_EN) check("status_ovf_full", read_data, 32'h6);
    idle("ovf_drain", 1'b1, 5);
    do_cycle("ovf_clear", 1'b0, 1'b1, MMIO + 4, 32'h4, 1'b0);
    check("ovf_cleared", 32'(dbg_overflow), 32'h0);

    // Full FIFO with simultaneous push and pop
    for (int i = 0; i < 4; i++) do_cycle("fp_fill", 1'b0, 1'b1, MMIO, 32'h200 + 32'(i), 1'b0);
    do_cycle("fp_pushpop", 1'b0, 1'b1, MMIO, 32'hAA, 1'b1);
    do_cycle("fp_status", 1'b0, 1'b0, MMIO + 4, 32'h0, 1'b0);
    if (FIFO_EN) check("status_still_full", read_data, 32'h2);
    idle("fp_drain", 1'b1, 5);

    // Reset mid-stream keeps RAM
    do_cycle("rst_ram", 1'b0, 1'b1, 32'h40, 32'hCAFE_F00D, 1'b0);
    do_cycle("rst_q", 1'b0, 1'b1, MMIO, 32'h55, 1'b0);
    do_cycle("rst_q", 1'b0, 1'b1, MMIO, 32'h66, 1'b0);
    do_cycle("rst_pulse", 1'b1, 1'b0, 32'h0, 32'h0, 1'b0);
    do_cycle("rst_after", 1'b0, 1'b0, 32'h40, 32'h0, 1'b1);
    check("rst_ram_kept", read_data, 32'hCAFE_F00D);
    check("rst_valid", 32'(dbg_valid), 32'h0);

    // Randomized traffic
    for (int n = 0; n < 600; n++) begin
      pick = int'($urandom_range(0, 9));
      if (pick < 4) begin
        ra = $urandom;
        if (is_mmio(ra)) ra[31] = 1'b0;
        do_cycle("rnd_ram", 1'b0, 1'($urandom_range(0, 1)), ra, $urandom,
                 1'($urandom_range(0, 1)));
      end else begin
        case ($urandom_range(0, 3))
          0, 1:    ra = MMIO;
          2:       ra = MMIO + 4;
          default: ra = MMIO + 32'($urandom_range(8, 255));
        endcase
        do_cycle("rnd_mmio", 1'b0, 1'($urandom_range(0, 3) != 0), ra, $urandom,
                 1'($urandom_range(0, 2) == 0));
      end
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
